// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: counts in-flight writes per register and stalls issue of any
// instruction whose sources (or saturated destination) still have writes pending.
module reg_write_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic               issue_we,
  input  logic [4:0]         issue_rd,
  input  logic [4:0]         issue_rs,
  input  logic [4:0]         issue_rt,
  input  logic               use_rs,
  input  logic               use_rt,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  output logic               stall,
  output logic               busy,
  output logic [5+CNT_W-1:0] outstanding,
  output logic               err
);

  localparam int unsigned OutW = 5 + CNT_W;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [OutW-1:0] OutOne = OutW'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [1:31];
  logic [CNT_W-1:0] cnt   [32];
  logic             hazard_rs, hazard_rt, hazard_rd;
  logic             accept, inc_any, wb_hit, dec_any, err_set;
  logic [OutW-1:0]  outstanding_d;

  // Register 0 has no storage and always reads as an idle counter.
  always_comb begin
    cnt[0] = '0;
    for (int r = 1; r < 32; r++) begin
      cnt[r] = cnt_q[r];
    end
  end

  always_comb begin
    hazard_rs = use_rs && (issue_rs != 5'd0) && (cnt[issue_rs] != '0);
    hazard_rt = use_rt && (issue_rt != 5'd0) && (cnt[issue_rt] != '0);
    hazard_rd = issue_we && (issue_rd != 5'd0) && (cnt[issue_rd] == CntMax);
    stall     = issue_valid && (hazard_rs || hazard_rt || hazard_rd);
    accept    = issue_valid && !stall;
    inc_any   = accept && issue_we && (issue_rd != 5'd0);
    wb_hit    = wb_valid && (wb_rd != 5'd0);
    dec_any   = wb_hit && (cnt[wb_rd] != '0);
    // A same-cycle issue to the register being written back covers the writeback.
    err_set   = wb_hit && (cnt[wb_rd] == '0) && !flush && !(inc_any && (issue_rd == wb_rd));
  end

  always_comb begin
    outstanding_d = outstanding;
    if (inc_any && !dec_any) begin
      outstanding_d = outstanding + OutOne;
    end else if (dec_any && !inc_any) begin
      outstanding_d = outstanding - OutOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_any && (issue_rd == 5'(r)) && !(dec_any && (wb_rd == 5'(r)))) begin
          cnt_q[r] <= cnt_q[r] + CntOne;
        end else if (dec_any && (wb_rd == 5'(r)) && !(inc_any && (issue_rd == 5'(r)))) begin
          cnt_q[r] <= cnt_q[r] - CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (flush) begin
        outstanding <= '0;
        busy        <= 1'b0;
      end else begin
        outstanding <= outstanding_d;
        busy        <= (outstanding_d != '0);
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Bench for reg_write_scoreboard: directed scenarios plus randomized traffic, all checked
// against a per-register count model.
module tb_reg_write_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             issue_valid = 1'b0, issue_we = 1'b0;
  logic [4:0]       issue_rd = '0, issue_rs = '0, issue_rt = '0;
  logic             use_rs = 1'b0, use_rt = 1'b0;
  logic             wb_valid = 1'b0;
  logic [4:0]       wb_rd = '0;
  logic             stall, busy, err;
  logic [5+CNT_W-1:0] outstanding;

  reg_write_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .use_rs(use_rs), .use_rt(use_rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .busy(busy), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_cnt [32];
  bit m_err = 0;
  int seen_stall;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_total();
    int s = 0;
    for (int r = 1; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = (use_rs && issue_rs != 0 && m_cnt[issue_rs] != 0) ||
        (use_rt && issue_rt != 0 && m_cnt[issue_rt] != 0) ||
        (issue_we && issue_rd != 0 && m_cnt[issue_rd] == MAXC);
    return issue_valid && h;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;
  endtask

  // Model one clock edge from the inputs currently driven and the pre-edge counts.
  task automatic m_edge(input bit stl);
    bit acc_wr;
    int pre;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      return;
    end
    acc_wr = issue_valid && !stl && issue_we && issue_rd != 0;
    pre = m_cnt[wb_rd];
    if (acc_wr) m_cnt[issue_rd]++;
    if (wb_valid && wb_rd != 0) begin
      if (pre > 0) m_cnt[wb_rd]--;
      else if (!(acc_wr && issue_rd == wb_rd)) m_err = 1;
    end
  endtask

  task automatic step(input bit v, input bit we, input int rd, input int rs, input int rt,
                      input bit urs, input bit urt, input bit wv, input int wrd, input bit fl);
    bit es;
    @(negedge clk);
    issue_valid = v; issue_we = we; issue_rd = 5'(rd); issue_rs = 5'(rs); issue_rt = 5'(rt);
    use_rs = urs; use_rt = urt; wb_valid = wv; wb_rd = 5'(wrd); flush = fl;
    #1;
    es = m_stall();
    seen_stall = int'(stall);
    check_val("stall", int'(stall), int'(es));
    @(posedge clk);
    m_edge(es);
    #1;
    check_val("outstanding", int'(outstanding), m_total());
    check_val("busy", int'(busy), int'(m_total() != 0));
    check_val("err", int'(err), int'(m_err));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a low clock phase, with an issue still presented.
  task automatic async_reset(input string tag);
    @(negedge clk);
    issue_valid = 1; issue_we = 1; issue_rd = 5'd3; issue_rs = 5'd3; use_rs = 1;
    wb_valid = 0; flush = 0;
    #2 reset = 1;
    #1;
    m_reset();
    check_val({tag, "_out"}, int'(outstanding), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_err"}, int'(err), 0);
    check_val({tag, "_stall"}, int'(stall), 0);
    @(negedge clk);
    reset = 0;
    issue_valid = 0; issue_we = 0; use_rs = 0;
  endtask

  initial begin
    m_reset();
    #2;
    check_val("rst_out", int'(outstanding), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_err", int'(err), 0);
    issue_valid = 1; issue_we = 1; issue_rd = 5'd5; use_rs = 1; issue_rs = 5'd5;
    #1;
    check_val("rst_stall", int'(stall), 0);
    issue_valid = 0; issue_we = 0; use_rs = 0;
    @(negedge clk);
    reset = 0;

    // Basic hazard on r5
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    check_val("tp1_out", int'(outstanding), 1);
    check_val("tp1_busy", int'(busy), 1);
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    check_val("tp1_stall", seen_stall, 1);
    step(1, 0, 0, 5, 0, 1, 0, 1, 5, 0);
    check_val("tp1_nobypass", seen_stall, 1);
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    check_val("tp1_release", seen_stall, 0);
    check_val("tp1_idle", int'(busy), 0);

    // Register 0 is ignored
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    check_val("tp2_stall", seen_stall, 0);
    check_val("tp2_out", int'(outstanding), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check_val("tp2_err", int'(err), 0);

    // Saturation on r7
    for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check_val("tp3_out3", int'(outstanding), 3);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check_val("tp3_sat_stall", seen_stall, 1);
    check_val("tp3_still3", int'(outstanding), 3);
    step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    check_val("tp3_wb_stall", seen_stall, 1);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check_val("tp3_issue", seen_stall, 0);
    check_val("tp3_out_back", int'(outstanding), 3);

    // Same-cycle issue and writeback on r9
    step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 0, 1, 9, 0);
    check_val("tp4_out", int'(outstanding), 4);
    check_val("tp4_err", int'(err), 0);
    step(1, 0, 0, 9, 0, 1, 0, 0, 0, 0);
    check_val("tp4_r9_pending", seen_stall, 1);

    // Sticky error
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    check_val("tp5_err", int'(err), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_val("tp5_err_flush", int'(err), 1);
    check_val("tp5_flush_out", int'(outstanding), 0);
    async_reset("tp5_rst");

    // Flush beats concurrent issue and writeback
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0, 1, 4, 1);
    check_val("tp6_out", int'(outstanding), 0);
    check_val("tp6_busy", int'(busy), 0);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    async_reset("tp6_rst");

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 6)),
             $urandom_range(0, 39) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
